// File: rtl/gpu_pkg.sv
// Shared definitions for the VRAM port-B controller: register map, FSM states
// and the widths of the text-mode character RAM.
package gpu_pkg;

    localparam int VRAM_ADDR_W = 10;
    localparam int VRAM_DATA_W = 16;
    localparam int VRAM_CELLS  = 1 << VRAM_ADDR_W;
    localparam int BUS_W       = 32;

    localparam logic [1:0] REG_CURSOR = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_FILL   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // bit0 = flipV_en, bit1 = flipH_en
    localparam logic [1:0] CTRL_RST = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_RD_ADDR,
        ST_RD_ACK,
        ST_FILL
    } state_t;

endpackage

// File: rtl/vram_fill_engine.sv
// Sweeps every VRAM cell once, writing a constant value. One idle cycle
// after start (the bus ACK cycle), then CELLS back-to-back write cycles.
module vram_fill_engine
    import gpu_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int CELLS  = VRAM_CELLS
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_value,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic              o_busy,
    output logic              o_done
);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic              r_busy;
    logic              w_last;

    assign w_last = (r_addr == ADDR_W'(CELLS - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_we   <= 1'b0;
            r_busy <= 1'b0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_busy <= 1'b1;
                r_data <= i_value;
            end
        end else if (!r_we) begin
            r_we   <= 1'b1;
            r_addr <= '0;
        end else if (w_last) begin
            r_we   <= 1'b0;
            r_busy <= 1'b0;
            r_addr <= '0;
        end else begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_we   = r_we;
    assign o_busy = r_busy;
    assign o_done = r_we & w_last;

endmodule

// File: rtl/vram_port_ctrl.sv
// Bus slave owning VRAM port B: cursor-based cell access, hardware fill and
// display flip control. The fill engine has absolute priority on port B.
module vram_port_ctrl
    import gpu_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int CELLS  = VRAM_CELLS
) (
    input  logic              clk,
    input  logic              W_RST,
    input  logic              W_STB,
    input  logic              W_WE,
    input  logic [31:0]       W_ADDR,
    input  logic [31:0]       W_DAT_I,
    output logic [31:0]       W_DAT_O,
    output logic              W_ACK,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_q,
    output logic              flipV_en,
    output logic              flipH_en
);

    state_t            r_state;
    logic              r_ack;
    logic [BUS_W-1:0]  r_dat_o;
    logic [ADDR_W-1:0] r_cursor;
    logic [1:0]        r_ctrl;
    logic              r_wr_we;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [1:0]        w_reg;
    logic              w_is_data_rd;
    logic              w_permit;
    logic              w_accept;
    logic              w_fill_start;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_data;
    logic              w_fill_we;
    logic              w_fill_busy;
    logic              w_fill_done;
    logic              w_unused;

    assign w_unused     = &{1'b0, W_ADDR[31:4], W_ADDR[1:0], W_DAT_I[31:16]};
    assign w_reg        = W_ADDR[3:2];
    assign w_is_data_rd = (w_reg == REG_DATA) && !W_WE;

    // During a fill only register-file traffic may run alongside the sweep.
    always_comb begin
        w_permit = 1'b0;
        case (r_state)
            ST_IDLE: w_permit = 1'b1;
            ST_FILL: w_permit = (w_reg != REG_DATA) && !((w_reg == REG_FILL) && W_WE);
            default: w_permit = 1'b0;
        endcase
    end

    assign w_accept     = W_STB && !r_ack && w_permit;
    assign w_fill_start = w_accept && (w_reg == REG_FILL) && W_WE;

    vram_fill_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CELLS  (CELLS)
    ) u_fill (
        .clk     (clk),
        .i_rst   (W_RST),
        .i_start (w_fill_start),
        .i_value (W_DAT_I[DATA_W-1:0]),
        .o_addr  (w_fill_addr),
        .o_data  (w_fill_data),
        .o_we    (w_fill_we),
        .o_busy  (w_fill_busy),
        .o_done  (w_fill_done)
    );

    always_ff @(posedge clk) begin
        if (W_RST) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_dat_o   <= '0;
            r_cursor  <= '0;
            r_ctrl    <= CTRL_RST;
            r_wr_we   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_wr_we <= 1'b0;

            if (w_accept && !w_is_data_rd) begin
                r_ack <= 1'b1;
                case (w_reg)
                    REG_CURSOR: begin
                        if (W_WE) r_cursor <= W_DAT_I[ADDR_W-1:0];
                        else      r_dat_o  <= {{(BUS_W-ADDR_W){1'b0}}, r_cursor};
                    end
                    REG_DATA: begin
                        r_wr_we   <= 1'b1;
                        r_wr_addr <= r_cursor;
                        r_wr_data <= W_DAT_I[DATA_W-1:0];
                        r_cursor  <= r_cursor + ADDR_W'(1);
                    end
                    REG_FILL: begin
                        if (!W_WE) r_dat_o <= {{(BUS_W-1){1'b0}}, w_fill_busy};
                    end
                    default: begin
                        if (W_WE) r_ctrl  <= W_DAT_I[1:0];
                        else      r_dat_o <= {{(BUS_W-2){1'b0}}, r_ctrl};
                    end
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= w_is_data_rd ? ST_RD_ADDR : ST_ACK;
                end
                ST_ACK:     r_state <= w_fill_busy ? ST_FILL : ST_IDLE;
                ST_RD_ADDR: begin
                    // Port B has followed the cursor since the accept cycle.
                    r_state <= ST_RD_ACK;
                    r_ack   <= 1'b1;
                    r_dat_o <= {{(BUS_W-DATA_W){1'b0}}, vram_q};
                end
                ST_RD_ACK:  r_state <= ST_IDLE;
                ST_FILL: begin
                    if (w_fill_done) r_state <= ST_IDLE;
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign vram_we   = w_fill_we | r_wr_we;
    assign vram_addr = w_fill_busy ? w_fill_addr : (r_wr_we ? r_wr_addr : r_cursor);
    assign vram_data = w_fill_busy ? w_fill_data : r_wr_data;

    assign W_ACK    = r_ack;
    assign W_DAT_O  = r_dat_o;
    assign flipV_en = r_ctrl[0];
    assign flipH_en = r_ctrl[1];

endmodule

// File: doc/vram_port_ctrl.md
Name: vram_port_ctrl

Overview:
Bus-slave controller that owns VRAM port B, the write/readback port of the text-mode character RAM, and configures the display flip logic. It sequences CPU single-cell accesses through an auto-incrementing cursor. It runs a hardware fill engine that clears or paints all 1024 character cells. It arbitrates port B between CPU accesses and the fill engine, and sits between the system bus and the GPU core's VRAM/flip inputs.

Parameters:
ADDR_W, 10, VRAM cell address width ({row[3:0], col[5:0]})
DATA_W, 16, character code width
CELLS, 1024, number of cells swept by a fill (2**ADDR_W)

Ports:
clk  in  1  system clock
W_RST  in  1  synchronous, active-high reset
W_STB  in  1  bus strobe; master holds it until W_ACK
W_WE  in  1  1 = write, 0 = read (qualified by W_STB)
W_ADDR  in  32  byte address; only [3:2] decoded
W_DAT_I  in  32  write data
W_DAT_O  out  32  read data, valid while W_ACK=1
W_ACK  out  1  single-cycle acknowledge
vram_addr  out  ADDR_W  port B address
vram_data  out  DATA_W  port B write data
vram_we  out  1  port B write enable
vram_q  in  DATA_W  port B read data, 1-cycle registered latency
flipV_en  out  1  vertical flip enable to display path
flipH_en  out  1  horizontal flip enable to display path

Behaviour:
- Reset: W_ACK=0, W_DAT_O=0, vram_we=0, vram_addr=0, vram_data=0, cursor=0, busy=0, flipV_en=1, flipH_en=0, state=IDLE. Reset mid-fill aborts the fill; no vram_we on the cycle after W_RST.
- Register map (W_ADDR[3:2]):
  - 0 CURSOR: R/W, bits[9:0]; reads zero-extended.
  - 1 DATA: W writes W_DAT_I[15:0] to vram[cursor], then cursor+1. R returns vram[cursor] zero-extended; cursor unchanged.
  - 2 FILL: W starts a fill with W_DAT_I[15:0]. R returns bit0=busy.
  - 3 CTRL: R/W; bit0=flipV_en, bit1=flipH_en.
- Accept rule: a request is accepted when W_STB=1, W_ACK=0 and state permits. No accept occurs in a cycle where W_ACK=1.
- Latency:
  - CURSOR, CTRL, FILL-status read, DATA write, FILL write: W_ACK 1 cycle after accept.
  - DATA read: W_ACK 2 cycles after accept (addr cycle, then vram_q capture).
- DATA write: vram_we=1 for exactly one cycle, the cycle after accept, with vram_addr=old cursor. Cursor updates in the same cycle.
- Cursor arithmetic: ADDR_W-bit modulo; 1023+1 wraps to 0. CURSOR write ignores bits above [9:0].
- State machine:
  - IDLE -> ACK on any non-DATA-read accept.
  - IDLE -> RD_ADDR on DATA-read accept; RD_ADDR -> RD_ACK; RD_ACK -> IDLE.
  - ACK -> IDLE, except after a FILL write: ACK -> FILL.
  - FILL: vram_we=1 every cycle; vram_addr runs 0..CELLS-1; vram_data = fill value. busy=1 from the ACK cycle until the last write. After addr CELLS-1, -> IDLE with busy=0 and vram_we=0 next cycle.
  - Fill occupies exactly 1024 consecutive we cycles; cursor is not modified.
- Arbitration during FILL:
  - CURSOR, CTRL and FILL-status reads are serviced normally. They are acked in parallel; the fill sweep is not paused.
  - DATA accesses and FILL writes stall (no ACK) until the fill completes, then are accepted from IDLE.
  - The fill engine has absolute priority on port B.
- vram_we is never asserted in any state other than the DATA-write cycle and FILL.

Decomposition:
- Shared package gpu_pkg: register index constants (REG_CURSOR=0, REG_DATA=1, REG_FILL=2, REG_CTRL=3), state enum, VRAM_ADDR_W/VRAM_DATA_W, CTRL reset value (2'b01).
- One natural sub-module: vram_fill_engine (start, value -> addr counter, we, busy, done).
- Bus decode/FSM and CTRL/CURSOR registers stay in the top.

Test Plan:
1. Reset, then read CTRL -> W_DAT_O=0x1. Read CURSOR -> 0x0. No vram_we during or after reset.
2. Write CURSOR=5; write DATA 0x0041, then 0x0042 -> vram_we pulses at addr 5 data 0x41 and addr 6 data 0x42. CURSOR reads 7. Each W_ACK arrives 1 cycle after accept.
3. Write CURSOR=1023; write DATA 0x0058 -> write at addr 1023. CURSOR reads 0.
4. Preload vram_q model so addr 7 holds 0x1234; CURSOR=7; read DATA -> W_ACK 2 cycles after accept, W_DAT_O=0x00001234. CURSOR still 7.
5. Write FILL 0x0020 -> exactly 1024 consecutive vram_we cycles, addr 0..1023, data 0x20.
   - FILL-status read mid-sweep -> 0x1, acked in 1 cycle.
   - A DATA write issued mid-fill gets no ACK until after addr 1023, then writes at the cursor.
6. Start a fill, assert W_RST at addr 300 -> vram_we=0 next cycle; busy=0, flipV_en=1, cursor=0. A subsequent DATA write works normally.
